// File: rtl/line_fetch_engine.sv
// Cache line transfer engine: refills a line from external memory into the data RAM or
// writes a line back from it. Optional per-beat read error reporting via LINE_FETCH_ERR_EN.
module line_fetch_engine #(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int data_width = 32,
    parameter int list_width = 32,
    localparam int TW  = $clog2(list_depth),
    localparam int CW  = $clog2(list_width),
    localparam int OFF = $clog2(list_width * data_width / 8)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [1:0]            fetch_cmd,
    input  logic [TW-1:0]         fetch_tag,
    input  logic [addr_width-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_done,
    output logic                  mem_wen,
    output logic [TW+CW-1:0]      mem_waddr,
    output logic [data_width-1:0] mem_wdata,
    input  logic                  mem_wready,
    output logic                  mem_ren,
    output logic [TW+CW-1:0]      mem_raddr,
    input  logic                  mem_rready,
    input  logic [data_width-1:0] mem_rdata,
    input  logic                  mem_rdata_valid,
    output logic                  ext_req,
    output logic                  ext_we,
    output logic [addr_width-1:0] ext_addr,
    input  logic                  ext_gnt,
    input  logic [data_width-1:0] ext_rdata,
    input  logic                  ext_rvalid,
    output logic                  ext_rready,
    output logic [data_width-1:0] ext_wdata,
    output logic                  ext_wvalid,
    input  logic                  ext_wready
`ifdef LINE_FETCH_ERR_EN
    ,
    input  logic                  ext_rerr,
    output logic                  fetch_err
`endif
);

    // state   | meaning
    // IDLE    | waiting for fetch_req
    // EXT_REQ | external burst request outstanding
    // RD_DATA | refill beats external -> data RAM
    // WB_RD   | issue data RAM read for word cnt
    // WB_WAIT | wait for data RAM read return
    // WB_PUSH | present buffered word to external memory
    // DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE, EXT_REQ, RD_DATA, WB_RD, WB_WAIT, WB_PUSH, DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(list_width - 1);

    state_t                  state, state_nxt;
    logic [1:0]              cmd_q;
    logic [TW-1:0]           tag_q;
    logic [addr_width-1:0]   addr_q;
    logic [CW-1:0]           cnt;
    logic [data_width-1:0]   buf_q;
    logic                    beat_ok;
    logic                    beat_bad;
    logic                    unused_addr_bits;

    // Byte offset within the line never leaves the block.
    assign unused_addr_bits = ^fetch_addr[OFF-1:0];

    assign fetch_gnt = (state == IDLE) && rst_n;
    assign beat_ok   = ext_rvalid && mem_wready;

`ifdef LINE_FETCH_ERR_EN
    logic err_q;
    assign beat_bad  = ext_rerr;
    assign fetch_err = err_q;
`else
    assign beat_bad  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cmd_q  <= '0;
            tag_q  <= '0;
            addr_q <= '0;
            cnt    <= '0;
            buf_q  <= '0;
`ifdef LINE_FETCH_ERR_EN
            err_q  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (fetch_req && fetch_gnt) begin
                        cmd_q  <= fetch_cmd;
                        tag_q  <= fetch_tag;
                        addr_q <= {fetch_addr[addr_width-1:OFF], {OFF{1'b0}}};
                        cnt    <= '0;
`ifdef LINE_FETCH_ERR_EN
                        err_q  <= 1'b0;
`endif
                    end
                end
                RD_DATA: begin
                    if (beat_ok) begin
                        cnt <= cnt + 1'b1;
`ifdef LINE_FETCH_ERR_EN
                        if (beat_bad) err_q <= 1'b1;
`endif
                    end
                end
                WB_WAIT: if (mem_rdata_valid) buf_q <= mem_rdata;
                WB_PUSH: if (ext_wready) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        fetch_done = 1'b0;
        mem_wen    = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_ren    = 1'b0;
        mem_raddr  = '0;
        ext_req    = 1'b0;
        ext_we     = 1'b0;
        ext_addr   = '0;
        ext_rready = 1'b0;
        ext_wdata  = '0;
        ext_wvalid = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req && fetch_gnt)
                    state_nxt = fetch_cmd[1] ? DONE : EXT_REQ;
            end
            EXT_REQ: begin
                ext_req  = 1'b1;
                ext_addr = addr_q;
                ext_we   = (cmd_q == 2'b00);
                if (ext_gnt)
                    state_nxt = (cmd_q == 2'b01) ? RD_DATA : WB_RD;
            end
            RD_DATA: begin
                ext_rready = mem_wready;
                // An errored beat is still consumed, it just never reaches the RAM.
                mem_wen    = ext_rvalid && !beat_bad;
                mem_wdata  = ext_rdata;
                mem_waddr  = {tag_q, cnt};
                if (beat_ok && cnt == LAST)
                    state_nxt = DONE;
            end
            WB_RD: begin
                mem_ren   = 1'b1;
                mem_raddr = {tag_q, cnt};
                if (mem_rready)
                    state_nxt = WB_WAIT;
            end
            WB_WAIT: begin
                if (mem_rdata_valid)
                    state_nxt = WB_PUSH;
            end
            WB_PUSH: begin
                ext_wvalid = 1'b1;
                ext_wdata  = buf_q;
                if (ext_wready)
                    state_nxt = (cnt == LAST) ? DONE : WB_RD;
            end
            DONE: begin
                fetch_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_line_fetch_engine.sv
// Self-checking bench for line_fetch_engine: the bench plays external memory and the data RAM,
// both backed by plain arrays that double as the reference model.
module tb_line_fetch_engine;

    localparam int LW = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [1:0]  fetch_cmd = '0;
    logic [1:0]  fetch_tag = '0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_gnt, fetch_done;
    logic        mem_wen;
    logic [6:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wready = 1'b0;
    logic        mem_ren;
    logic [6:0]  mem_raddr;
    logic        mem_rready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rdata_valid = 1'b0;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr;
    logic        ext_gnt = 1'b0;
    logic [31:0] ext_rdata = '0;
    logic        ext_rvalid = 1'b0;
    logic        ext_rready;
    logic [31:0] ext_wdata;
    logic        ext_wvalid;
    logic        ext_wready = 1'b0;
`ifdef LINE_FETCH_ERR_EN
    logic        ext_rerr = 1'b0;
    logic        fetch_err;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] ram [0:127];
    logic [31:0] line_data [0:LW-1];

    always #5 clk = ~clk;

    line_fetch_engine dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_cmd(fetch_cmd), .fetch_tag(fetch_tag),
        .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rready(mem_rready),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_gnt(ext_gnt),
        .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid), .ext_rready(ext_rready),
        .ext_wdata(ext_wdata), .ext_wvalid(ext_wvalid), .ext_wready(ext_wready)
`ifdef LINE_FETCH_ERR_EN
        , .ext_rerr(ext_rerr), .fetch_err(fetch_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk(tag, 64'(|{fetch_gnt, fetch_done, mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr,
                       ext_req, ext_we, ext_addr, ext_rready, ext_wdata, ext_wvalid}), 64'd0);
    endtask

    task automatic quiet_inputs();
        fetch_req = 1'b0; ext_gnt = 1'b0; ext_rvalid = 1'b0; mem_wready = 1'b0;
        mem_rready = 1'b0; mem_rdata_valid = 1'b0; ext_wready = 1'b0;
`ifdef LINE_FETCH_ERR_EN
        ext_rerr = 1'b0;
`endif
    endtask

    // mode: 0 no stalls, 1 random stalls, 2 alternating mem_wready + late ext_gnt, 3 no stalls with 2-cycle RAM latency
    task automatic xfer(input logic [1:0] cmd, input int tag, input logic [31:0] addr,
                        input int mode, input int rst_at, input int err_beat);
        int c, k, done_c, last_wr_c, rd_lat, done_cnt;
        bit granted, req_seen, finished, aborted, act;
        bit refill, wb;
        logic [31:0] exp_addr, rd_word;
        refill = (cmd == 2'b01);
        wb     = (cmd == 2'b00);
        for (int i = 0; i < LW; i++) line_data[i] = $urandom;
        exp_addr = {addr[31:7], 7'b0};
        @(negedge clk);
        fetch_req = 1'b1; fetch_cmd = cmd; fetch_tag = 2'(tag); fetch_addr = addr;
        #1 chk("gnt_idle", 64'(fetch_gnt), 64'd1);
        c = 0; k = 0; done_c = -1; last_wr_c = -1; rd_lat = 0; done_cnt = 0;
        granted = 0; req_seen = 0; finished = 0; aborted = 0; act = 0; rd_word = '0;
        while (!finished && c < 3000) begin
            @(negedge clk);
            c++;
            if (rst_at >= 0 && granted && k == rst_at) begin
                rst_n = 1'b0;
                quiet_inputs();
                #1 chk_outputs_zero("rst_mid_outputs");
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                #1 chk("gnt_after_rst", 64'(fetch_gnt), 64'd1);
                aborted = 1;
                break;
            end
            // Requests outside IDLE must be ignored.
            fetch_req = 1'($urandom_range(0, 1));
            fetch_cmd = 2'($urandom); fetch_tag = 2'($urandom); fetch_addr = $urandom;
            mem_rdata_valid = 1'b0;
            if (rd_lat > 0) begin
                rd_lat--;
                if (rd_lat == 0) begin mem_rdata_valid = 1'b1; mem_rdata = rd_word; end
            end
            case (mode)
                1: begin
                    ext_gnt = 1'($urandom_range(0, 1)); ext_rvalid = 1'($urandom_range(0, 1));
                    mem_wready = 1'($urandom_range(0, 1)); mem_rready = 1'($urandom_range(0, 1));
                    ext_wready = 1'($urandom_range(0, 1));
                end
                2: begin
                    ext_gnt = (c >= 6); ext_rvalid = 1'b1; mem_wready = 1'(c % 2);
                    mem_rready = 1'b1; ext_wready = 1'b1;
                end
                default: begin
                    ext_gnt = 1'b1; ext_rvalid = 1'b1; mem_wready = 1'b1;
                    mem_rready = 1'b1; ext_wready = 1'b1;
                end
            endcase
            ext_rdata = (k < LW) ? line_data[k] : $urandom;
`ifdef LINE_FETCH_ERR_EN
            ext_rerr = (k == err_beat);
            if (c == 1) chk("err_cleared_on_gnt", 64'(fetch_err), 64'd0);
`endif
            #1;
            if (cmd[1]) act = act | mem_wen | mem_ren | ext_req | ext_wvalid | ext_rready;
            if (fetch_done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
                finished = 1;
`ifdef LINE_FETCH_ERR_EN
                chk("fetch_err_at_done", 64'(fetch_err), 64'(refill && err_beat >= 0));
`endif
            end
            if (!granted && !cmd[1]) begin
                if (req_seen) chk("ext_req_hold", 64'(ext_req), 64'd1);
                if (ext_req) begin
                    req_seen = 1;
                    chk("ext_addr", 64'(ext_addr), 64'(exp_addr));
                    chk("ext_we", 64'(ext_we), 64'(wb));
                end
            end
            if (refill && granted && k < LW) begin
                chk("ext_rready_mirror", 64'(ext_rready), 64'(mem_wready));
                if (ext_rvalid && ext_rready) begin
                    chk("mem_wen", 64'(mem_wen), 64'(k != err_beat));
                    chk("mem_waddr", 64'(mem_waddr), 64'(tag * LW + k));
                    chk("mem_wdata", 64'(mem_wdata), 64'(line_data[k]));
                    if (k != err_beat) ram[tag * LW + k] = line_data[k];
                    k++;
                end
            end
            if (wb && granted && k < LW) begin
                if (mem_ren && mem_rready) begin
                    chk("mem_raddr", 64'(mem_raddr), 64'(tag * LW + k));
                    rd_word = ram[tag * LW + k];
                    rd_lat = (mode == 3) ? 2 : $urandom_range(1, 3);
                end
                if (ext_wvalid && ext_wready) begin
                    chk("ext_wdata", 64'(ext_wdata), 64'(ram[tag * LW + k]));
                    k++;
                    last_wr_c = c;
                end
            end
            if (ext_req && ext_gnt) granted = 1;
        end
        if (aborted) return;
        chk("done_seen", 64'(finished), 64'd1);
        chk("beats", 64'(k), cmd[1] ? 64'd0 : 64'(LW));
        if (refill && mode == 0) chk("refill_done_cycle", 64'(done_c), 64'(LW + 2));
        if (wb) chk("wb_done_after_last", 64'(done_c), 64'(last_wr_c + 1));
        if (cmd[1]) begin
            chk("null_done_cycle", 64'(done_c), 64'd1);
            chk("null_no_activity", 64'(act), 64'd0);
        end
        @(negedge clk);
        quiet_inputs();
        #1;
        chk("done_one_cycle", 64'(fetch_done), 64'd0);
        chk("gnt_after_done", 64'(fetch_gnt), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = $urandom;
        quiet_inputs();
        #1 chk_outputs_zero("reset_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("gnt_after_reset", 64'(fetch_gnt), 64'd1);
        chk("done_after_reset", 64'(fetch_done), 64'd0);

        xfer(2'b01, 2, 32'h1234_5678, 0, -1, -1);
        for (int i = 0; i < LW; i++) chk("ram_after_refill", 64'(ram[64 + i]), 64'(line_data[i]));

        for (int i = 0; i < LW; i++) ram[32 + i] = 32'hA000_0000 + i;
        xfer(2'b00, 1, 32'h0000_4080, 3, -1, -1);
        xfer(2'b01, 3, $urandom, 2, -1, -1);
        xfer(2'b10, 0, $urandom, 0, -1, -1);
        xfer(2'b11, 1, $urandom, 0, -1, -1);
        xfer(2'b01, 0, $urandom, 0, 10, -1);
        xfer(2'b01, 0, $urandom, 1, -1, -1);
        for (int n = 0; n < 6; n++)
            xfer(2'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom, 1, -1, -1);
`ifdef LINE_FETCH_ERR_EN
        xfer(2'b01, 2, $urandom, 0, -1, 5);
        xfer(2'b01, 1, $urandom, 1, -1, -1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_fetch_engine.md
# line_fetch_engine

Line-transfer engine of the cache: the responder on the `fetch_*` interface driven by the cache read controller. It moves one full cache line per request.
- Refill: reads the line from external memory and writes it into the local data RAM at slot `fetch_tag`.
- Write-back: reads slot `fetch_tag` from the data RAM and writes it to external memory.

`fetch_done` signals completion back to the requester.

## Interface
- `addr_width`, 32, byte address width
- `list_depth`, 4, number of line slots; TW = $clog2(list_depth)
- `data_width`, 32, word width; must be 32
- `list_width`, 32, words per line; CW = $clog2(list_width); OFF = $clog2(list_width*data_width/8)
- Clock and reset: rst_n, asynchronous, active-low; clock clk.
- `clk`  in  1  clock
- `rst_n`  in  1  reset
- `fetch_req`  in  1  transfer request
- `fetch_cmd`  in  2  2'b01 refill, 2'b00 write-back, 2'b1x null
- `fetch_tag`  in  TW  line slot
- `fetch_addr`  in  addr_width  line byte address
- `fetch_gnt`  out  1  request accepted
- `fetch_done`  out  1  one-cycle completion pulse
- `mem_wen`, `mem_waddr`, `mem_wdata`  out  1/TW+CW/data_width  data RAM write port
- `mem_wready`  in  1  data RAM write accepted
- `mem_ren`, `mem_raddr`  out  1/TW+CW  data RAM read port
- `mem_rready`  in  1  data RAM read accepted
- `mem_rdata`, `mem_rdata_valid`  in  data_width/1  data RAM read return; arrives at least 1 cycle after the accepted read
- `ext_req`, `ext_we`, `ext_addr`  out  1/1/addr_width  external burst request; `ext_we`=1 means write
- `ext_gnt`  in  1  burst request accepted
- `ext_rdata`, `ext_rvalid`  in  data_width/1  refill beats
- `ext_rready`  out  1  refill beat accepted
- `ext_wdata`, `ext_wvalid`  out  data_width/1  write-back beats
- `ext_wready`  in  1  write-back beat accepted

## Operation
- States: IDLE, EXT_REQ, RD_DATA, WB_RD, WB_WAIT, WB_PUSH, DONE.
- `fetch_gnt` = (state==IDLE), combinational.
- On `fetch_req`&&`fetch_gnt`, capture `fetch_cmd`, `fetch_tag` and the aligned line address {`fetch_addr`[aw-1:OFF], OFF'b0}. Clear the beat counter `cnt` (CW bits).
- Next state after the handshake: cmd 2'b1x → DONE; otherwise → EXT_REQ.
- EXT_REQ:
  - Drive `ext_req`=1, `ext_addr`=aligned line address, `ext_we`=(cmd==00).
  - On `ext_gnt`, go to RD_DATA (refill) or WB_RD (write-back).
- RD_DATA (refill beats):
  - `ext_rready`=`mem_wready`.
  - `mem_wen`=`ext_rvalid`; `mem_wdata`=`ext_rdata`; `mem_waddr`={tag,cnt}.
  - A beat completes on `ext_rvalid`&&`mem_wready`, then `cnt`++.
  - Completion of the beat with `cnt`==list_width-1 → DONE.
- Write-back, one word at a time:
  - WB_RD: `mem_ren`=1, `mem_raddr`={tag,cnt}; on `mem_rready` → WB_WAIT.
  - WB_WAIT: on `mem_rdata_valid`, register `mem_rdata` into the word buffer → WB_PUSH.
  - WB_PUSH: `ext_wvalid`=1, `ext_wdata`=buffer; on `ext_wready`, `cnt`++ and go to WB_RD, or to DONE if `cnt`==list_width-1.
- DONE: `fetch_done`=1 for one cycle → IDLE.
- `cnt` wraps to 0 after the last beat. The order of beats is always 0..list_width-1.
- Inputs on `fetch_*` are ignored outside IDLE. The captured tag and address are stable for the whole transfer.

## Timing
- All outputs are 0 at reset, including `fetch_gnt` while rst_n is low. After reset the engine is in IDLE with `cnt`=0 and the buffer at 0.
- Async reset mid-transfer: return to IDLE at once and abandon the external burst. The external side must be reset together with this block.
- Refill latency with zero stalls, handshake at cycle 0:
  - EXT_REQ at cycle 1.
  - Beats at cycles 2..list_width+1.
  - `fetch_done` at cycle list_width+2.
- Write-back takes at least 3 cycles per word (WB_RD → WB_WAIT → WB_PUSH). `fetch_done` follows the last `ext_wready` by one cycle.
- Null command: `fetch_done` at cycle 1. No `mem_*` or `ext_*` activity.
- A new `fetch_req` is granted no earlier than the cycle after `fetch_done`.
- `mem_wen`, `ext_req`, `ext_wvalid` and `mem_ren` hold until they are accepted. Stalls of any length are legal.

## Configuration
- Macro `LINE_FETCH_ERR_EN`.
- When defined:
  - Adds input `ext_rerr` (qualifies `ext_rvalid`) and output `fetch_err`.
  - A beat with `ext_rerr`=1 is still consumed, but its `mem_wen` is suppressed.
  - `fetch_err` is sticky. It is valid together with `fetch_done` and clears on the next `fetch_gnt` handshake.
- When undefined, neither port exists and every beat is written.

## Test plan
- Refill, list_width=32, tag=2, addr 0x1234_5678, zero stalls → `ext_addr`=0x1234_5600, `ext_we`=0; 32 writes to `mem_waddr` 64..95 with data as sent; `fetch_done` at cycle 34.
- Write-back, tag=1, data RAM word i = 0xA000_0000+i, `mem_rdata_valid` 2 cycles after the read → `ext_we`=1; `ext_wdata` sequence 0xA000_0000..0xA000_001F; one `fetch_done` pulse.
- Refill with `mem_wready` low on every other cycle and `ext_gnt` delayed 5 cycles → no lost or duplicated beat; `ext_rready` mirrors `mem_wready`; `fetch_done` only after the 32nd write.
- `fetch_cmd`=2'b10 → `fetch_done` the next cycle; no `ext_req` or `mem_*` activity; `fetch_gnt` high again the cycle after.
- rst_n low during beat 10 of a refill → all outputs 0; the next request restarts at `cnt`=0.
- With `LINE_FETCH_ERR_EN`, `ext_rerr` on beat 5 → 31 writes (slot word 5 not written); `fetch_err`=1 with `fetch_done`; cleared on the next handshake.
